// File: rtl/brc_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module      : brc_resolve_unit
//  Description : RV32I conditional-branch resolution stage.
//                Turns comparator flags and funct3 into a branch outcome, a
//                target and a redirect PC, and flags mispredicts and illegal
//                encodings. The result sits in a one-entry output register
//                behind valid/ready handshakes. A table of 2-bit saturating
//                counters is trained on every accepted legal branch. Fetch
//                reads the table combinationally as a branch predictor.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    IDX_W          predictor index width (2^IDX_W counters, PC[IDX_W+1:2])
//  Ports
//    i_clk          clock, rising edge
//    i_reset        asynchronous active-high reset
//    i_req_valid    branch request valid
//    o_req_ready    request can be accepted this cycle
//    i_funct3       branch funct3
//    i_pc           PC of the branch
//    i_imm          sign-extended B-type immediate
//    i_br_equal     comparator flag A == B
//    i_br_less_u    comparator flag A < B (unsigned)
//    i_br_less_s    comparator flag A < B (signed)
//    i_pred_taken   prediction used by fetch for this branch
//    o_rsp_valid    result register holds a valid result
//    i_rsp_ready    downstream consumes the result
//    o_taken        resolved outcome
//    o_target       pc + imm
//    o_redirect_pc  target if taken, else pc + 4
//    o_mispredict   outcome differs from the prediction (never for illegal)
//    o_illegal      funct3 is 010 or 011
//    i_lookup_pc    fetch-side predictor lookup address
//    o_lookup_taken MSB of the counter at i_lookup_pc (combinational)
// ============================================================================
module brc_resolve_unit #(
  parameter int IDX_W = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  // request side
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_imm,
  input  logic        i_br_equal,
  input  logic        i_br_less_u,
  input  logic        i_br_less_s,
  input  logic        i_pred_taken,
  // response side
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic        o_taken,
  output logic [31:0] o_target,
  output logic [31:0] o_redirect_pc,
  output logic        o_mispredict,
  output logic        o_illegal,
  // predictor lookup
  input  logic [31:0] i_lookup_pc,
  output logic        o_lookup_taken
);

  localparam int         c_DEPTH    = 1 << IDX_W;
  localparam logic [1:0] c_CTR_INIT = 2'b01;   // weakly not-taken
  localparam logic [1:0] c_CTR_MAX  = 2'b11;
  localparam logic [1:0] c_CTR_MIN  = 2'b00;

  localparam logic [2:0] c_F3_BEQ   = 3'b000;
  localparam logic [2:0] c_F3_BNE   = 3'b001;
  localparam logic [2:0] c_F3_BLT   = 3'b100;
  localparam logic [2:0] c_F3_BGE   = 3'b101;
  localparam logic [2:0] c_F3_BLTU  = 3'b110;
  localparam logic [2:0] c_F3_BGEU  = 3'b111;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic r_rsp_valid;
  logic w_accept;

  // The register frees up in the same cycle it is drained, which gives
  // one request per cycle while downstream stays ready.
  assign o_req_ready = ~r_rsp_valid | i_rsp_ready;
  assign w_accept    = i_req_valid & o_req_ready;

  // --------------------------------------------------------------------------
  // Decode and arithmetic
  // --------------------------------------------------------------------------
  logic        w_taken;
  logic        w_illegal;
  logic        w_mispredict;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_redirect;

  always_comb begin
    w_taken   = 1'b0;
    w_illegal = 1'b0;
    case (i_funct3)
      c_F3_BEQ:  w_taken = i_br_equal;
      c_F3_BNE:  w_taken = ~i_br_equal;
      c_F3_BLT:  w_taken = i_br_less_s;
      c_F3_BGE:  w_taken = ~i_br_less_s;
      c_F3_BLTU: w_taken = i_br_less_u;
      c_F3_BGEU: w_taken = ~i_br_less_u;
      default:   w_illegal = 1'b1;   // 010 / 011: never taken
    endcase
  end

  // Both sums wrap modulo 2^32; the carry out is intentionally dropped.
  assign w_target     = i_pc + i_imm;
  assign w_pc_plus4   = i_pc + 32'd4;
  assign w_redirect   = w_taken ? w_target : w_pc_plus4;
  // An illegal encoding is never reported as a mispredict, whatever fetch
  // predicted for it.
  assign w_mispredict = ~w_illegal & (w_taken ^ i_pred_taken);

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------
  logic        r_taken;
  logic [31:0] r_target;
  logic [31:0] r_redirect;
  logic        r_mispredict;
  logic        r_illegal;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rsp_valid  <= 1'b0;
      r_taken      <= 1'b0;
      r_target     <= 32'd0;
      r_redirect   <= 32'd0;
      r_mispredict <= 1'b0;
      r_illegal    <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid  <= 1'b1;
      r_taken      <= w_taken;
      r_target     <= w_target;
      r_redirect   <= w_redirect;
      r_mispredict <= w_mispredict;
      r_illegal    <= w_illegal;
    end else if (i_rsp_ready) begin
      // Only the valid bit drops on drain; data fields keep their last value.
      r_rsp_valid  <= 1'b0;
    end
  end

  assign o_rsp_valid   = r_rsp_valid;
  assign o_taken       = r_taken;
  assign o_target      = r_target;
  assign o_redirect_pc = r_redirect;
  assign o_mispredict  = r_mispredict;
  assign o_illegal     = r_illegal;

  // --------------------------------------------------------------------------
  // Predictor table: 2-bit saturating counters
  // --------------------------------------------------------------------------
  logic [1:0]       r_ctr [0:c_DEPTH-1];
  logic [IDX_W-1:0] w_upd_idx;
  logic [IDX_W-1:0] w_lookup_idx;
  logic [1:0]       w_ctr_cur;
  logic [1:0]       w_ctr_next;
  logic             w_upd_en;

  assign w_upd_idx    = i_pc[IDX_W+1:2];
  assign w_lookup_idx = i_lookup_pc[IDX_W+1:2];
  assign w_upd_en     = w_accept & ~w_illegal;
  assign w_ctr_cur    = r_ctr[w_upd_idx];

  always_comb begin
    w_ctr_next = w_ctr_cur;
    if (w_taken) begin
      if (w_ctr_cur != c_CTR_MAX) w_ctr_next = w_ctr_cur + 2'd1;
    end else begin
      if (w_ctr_cur != c_CTR_MIN) w_ctr_next = w_ctr_cur - 2'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_ctr[i] <= c_CTR_INIT;
      end
    end else if (w_upd_en) begin
      r_ctr[w_upd_idx] <= w_ctr_next;
    end
  end

  // Reads the registered table, so a same-cycle update at the same index is
  // not visible until after the edge.
  assign o_lookup_taken = r_ctr[w_lookup_idx][1];

  // Only the index bits of the lookup address matter.
  logic w_unused_lookup;
  assign w_unused_lookup = ^i_lookup_pc;

endmodule
`default_nettype wire

// File: tb/tb_brc_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_brc_resolve_unit
//  Description : Directed self-checking bench for brc_resolve_unit with
//                hand-computed expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_brc_resolve_unit;

  localparam int IDX_W = 4;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [2:0]  i_funct3 = 3'b000;
  logic [31:0] i_pc = 32'd0;
  logic [31:0] i_imm = 32'd0;
  logic        i_br_equal = 1'b0;
  logic        i_br_less_u = 1'b0;
  logic        i_br_less_s = 1'b0;
  logic        i_pred_taken = 1'b0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b1;
  logic        o_taken;
  logic [31:0] o_target;
  logic [31:0] o_redirect_pc;
  logic        o_mispredict;
  logic        o_illegal;
  logic [31:0] i_lookup_pc = 32'd0;
  logic        o_lookup_taken;

  brc_resolve_unit #(.IDX_W(IDX_W)) u_dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_funct3      (i_funct3),
    .i_pc          (i_pc),
    .i_imm         (i_imm),
    .i_br_equal    (i_br_equal),
    .i_br_less_u   (i_br_less_u),
    .i_br_less_s   (i_br_less_s),
    .i_pred_taken  (i_pred_taken),
    .o_rsp_valid   (o_rsp_valid),
    .i_rsp_ready   (i_rsp_ready),
    .o_taken       (o_taken),
    .o_target      (o_target),
    .o_redirect_pc (o_redirect_pc),
    .o_mispredict  (o_mispredict),
    .o_illegal     (o_illegal),
    .i_lookup_pc   (i_lookup_pc),
    .o_lookup_taken(o_lookup_taken)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic set_req(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                         input logic eq, input logic lu, input logic ls, input logic pred);
    i_funct3     = f3;
    i_pc         = pc;
    i_imm        = imm;
    i_br_equal   = eq;
    i_br_less_u  = lu;
    i_br_less_s  = ls;
    i_pred_taken = pred;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // One predictor update at pc=0x8 (index 2); BEQ/BNE with eq=1 give
  // taken/not-taken. Lookup is checked before and after the update edge.
  task automatic train(input logic tk, input logic exp_before, input logic exp_after, input string tag);
    set_req(tk ? 3'b000 : 3'b001, 32'h8, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    i_lookup_pc = 32'h8;
    i_req_valid = 1'b1;
    #1;
    check({tag, "_pre"}, {31'd0, o_lookup_taken}, {31'd0, exp_before});
    step();
    i_req_valid = 1'b0;
    check({tag, "_post"}, {31'd0, o_lookup_taken}, {31'd0, exp_after});
  endtask

  localparam logic [7:0] c_EXP_TAKEN   = 8'b1001_0001;
  localparam logic [7:0] c_EXP_ILLEGAL = 8'b0000_1100;

  initial begin
    logic [7:0] exp_taken;
    logic [7:0] exp_ill;
    exp_taken = c_EXP_TAKEN;
    exp_ill   = c_EXP_ILLEGAL;

    // ---------------- power-on reset state
    #2;
    check("por_valid",  {31'd0, o_rsp_valid}, 32'd0);
    check("por_ready",  {31'd0, o_req_ready}, 32'd1);
    check("por_target", o_target, 32'd0);
    check("por_lookup", {31'd0, o_lookup_taken}, 32'd0);
    #10;
    i_reset = 1'b0;

    // ---------------- mid-operation asynchronous reset
    i_rsp_ready = 1'b0;
    set_req(3'b000, 32'h8, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0);
    i_req_valid = 1'b1;
    step();
    i_req_valid = 1'b0;
    i_lookup_pc = 32'h8;
    #1;
    check("pre_rst_valid",  {31'd0, o_rsp_valid}, 32'd1);
    check("pre_rst_target", o_target, 32'h28);
    check("pre_rst_lookup", {31'd0, o_lookup_taken}, 32'd1);
    #1;
    i_reset = 1'b1;
    #1;
    check("rst_valid",    {31'd0, o_rsp_valid}, 32'd0);
    check("rst_taken",    {31'd0, o_taken}, 32'd0);
    check("rst_target",   o_target, 32'd0);
    check("rst_redirect", o_redirect_pc, 32'd0);
    check("rst_mispred",  {31'd0, o_mispredict}, 32'd0);
    check("rst_illegal",  {31'd0, o_illegal}, 32'd0);
    check("rst_ready",    {31'd0, o_req_ready}, 32'd1);
    check("rst_lookup",   {31'd0, o_lookup_taken}, 32'd0);
    i_reset = 1'b0;
    i_rsp_ready = 1'b1;
    step();

    // ---------------- decode sweep (eq=1, less_u=0, less_s=1, pred=0)
    for (int f = 0; f < 8; f++) begin
      set_req(f[2:0], 32'h100, 32'h20, 1'b1, 1'b0, 1'b1, 1'b0);
      i_req_valid = 1'b1;
      step();
      check($sformatf("dec%0d_valid", f),   {31'd0, o_rsp_valid}, 32'd1);
      check($sformatf("dec%0d_taken", f),   {31'd0, o_taken}, {31'd0, exp_taken[f]});
      check($sformatf("dec%0d_illegal", f), {31'd0, o_illegal}, {31'd0, exp_ill[f]});
      check($sformatf("dec%0d_redirect", f), o_redirect_pc, exp_taken[f] ? 32'h120 : 32'h104);
      check($sformatf("dec%0d_mispred", f), {31'd0, o_mispredict}, {31'd0, exp_taken[f]});
    end

    // ---------------- wrap-around and negative immediate
    set_req(3'b000, 32'hFFFF_FFFC, 32'h8, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    check("wrap_target",   o_target, 32'h4);
    check("wrap_redirect", o_redirect_pc, 32'h4);
    check("wrap_mispred",  {31'd0, o_mispredict}, 32'd0);
    set_req(3'b001, 32'hFFFF_FFFC, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("wrap_nt_taken",    {31'd0, o_taken}, 32'd0);
    check("wrap_nt_redirect", o_redirect_pc, 32'h0);
    set_req(3'b000, 32'h40, 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("neg_target",   o_target, 32'h30);
    check("neg_redirect", o_redirect_pc, 32'h30);
    i_req_valid = 1'b0;
    step();
    check("drain_valid", {31'd0, o_rsp_valid}, 32'd0);

    // ---------------- backpressure
    i_rsp_ready = 1'b0;
    set_req(3'b100, 32'h200, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0);
    i_req_valid = 1'b1;
    step();
    // A different request stays offered while the result is held.
    set_req(3'b111, 32'h300, 32'h4, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_valid", i),  {31'd0, o_rsp_valid}, 32'd1);
      check($sformatf("bp%0d_ready", i),  {31'd0, o_req_ready}, 32'd0);
      check($sformatf("bp%0d_target", i), o_target, 32'h210);
      check($sformatf("bp%0d_taken", i),  {31'd0, o_taken}, 32'd1);
      step();
    end
    i_rsp_ready = 1'b1;
    #1;
    check("bp_ready_up", {31'd0, o_req_ready}, 32'd1);
    step();
    i_req_valid = 1'b0;
    check("b2b_valid",   {31'd0, o_rsp_valid}, 32'd1);
    check("b2b_target",  o_target, 32'h304);
    check("b2b_mispred", {31'd0, o_mispredict}, 32'd0);
    step();
    check("b2b_drain", {31'd0, o_rsp_valid}, 32'd0);

    // ---------------- predictor training at pc=0x8 (starts at 01)
    train(1'b1, 1'b0, 1'b1, "tr_t1");   // 01 -> 10
    train(1'b1, 1'b1, 1'b1, "tr_t2");   // 10 -> 11
    train(1'b1, 1'b1, 1'b1, "tr_t3");   // 11 -> 11 (saturated)
    train(1'b0, 1'b1, 1'b1, "tr_n1");   // 11 -> 10
    train(1'b0, 1'b1, 1'b0, "tr_n2");   // 10 -> 01
    train(1'b0, 1'b0, 1'b0, "tr_n3");   // 01 -> 00
    train(1'b0, 1'b0, 1'b0, "tr_n4");   // 00 -> 00 (saturated)
    train(1'b1, 1'b0, 1'b0, "tr_t4");   // 00 -> 01
    train(1'b1, 1'b0, 1'b1, "tr_t5");   // 01 -> 10

    // ---------------- mispredict and illegal
    set_req(3'b001, 32'h10, 32'h40, 1'b1, 1'b0, 1'b0, 1'b1);
    i_req_valid = 1'b1;
    step();
    check("mp_taken",    {31'd0, o_taken}, 32'd0);
    check("mp_mispred",  {31'd0, o_mispredict}, 32'd1);
    check("mp_redirect", o_redirect_pc, 32'h14);
    check("mp_illegal",  {31'd0, o_illegal}, 32'd0);
    // Counter at index 2 is 10; an illegal update would drop it to 01.
    set_req(3'b011, 32'h8, 32'h40, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    i_req_valid = 1'b0;
    check("ill_illegal",  {31'd0, o_illegal}, 32'd1);
    check("ill_mispred",  {31'd0, o_mispredict}, 32'd0);
    check("ill_taken",    {31'd0, o_taken}, 32'd0);
    check("ill_redirect", o_redirect_pc, 32'hC);
    check("ill_lookup",   {31'd0, o_lookup_taken}, 32'd1);
    step();
    check("end_valid", {31'd0, o_rsp_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
